hnf_mshr_addr_cam: RTL and testbench

Parametrised MSHR address CAM for the HN-F. It holds one cache-line address per MSHR entry and detects same-line hazards for incoming RXREQ allocations and for cache-pipeline requests against pending L3 evictions. Same-line requests are chained youngest-last, and a single registered wake-up is issued when a chained predecessor retires. It sits between hnf_link_rxreq_parse/hnf_mshr_qos, hnf_mshr_ctl and hnf_cache_pipeline, and serves N address read ports to the TX wrappers.

---
 rtl/hnf_mshr_addr_cam.sv | 220 ++++++++++++++++++++++
 tb/tb_hnf_mshr_addr_cam.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hnf_mshr_addr_cam.sv
// MSHR address CAM for the HN-F. Holds one cache-line address per MSHR entry,
// flags same-line hazards for RXREQ allocations (against TAIL entries) and for
// cache-pipeline requests (against EVICT entries), chains same-line requests
// youngest-last and issues a registered wake-up when a chained predecessor
// retires.
module hnf_mshr_addr_cam #(
  parameter int ENTRIES  = 16,
  parameter int IDX_W    = 4,
  parameter int ADDR_W   = 48,
  parameter int BLK_OFF  = 6,
  parameter int RD_PORTS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid_s0,
  input  logic [ADDR_W-1:0]            req_addr_s0,
  input  logic                         alloc_en_s1,
  input  logic [IDX_W-1:0]             alloc_idx_s1,
  output logic                         req_hazard_s1,
  output logic [IDX_W-1:0]             req_hazard_idx_s1,
  output logic [ENTRIES-1:0]           req_hazard_vec_s1,
  input  logic                         evict_valid_sx7,
  input  logic [IDX_W-1:0]             evict_idx_sx7,
  input  logic [ADDR_W-1:0]            evict_addr_sx7,
  input  logic                         pipe_valid_sx2,
  input  logic [ADDR_W-1:0]            pipe_addr_sx2,
  input  logic [IDX_W-1:0]             pipe_idx_sx2,
  output logic                         pipe_hazard_sx3,
  output logic [ENTRIES-1:0]           pipe_hazard_vec_sx3,
  output logic [ENTRIES-1:0]           pipe_sleep_vec_sx3,
  input  logic                         retire_valid_sx1,
  input  logic [IDX_W-1:0]             retire_idx_sx1,
  output logic                         wake_valid_q,
  output logic [IDX_W-1:0]             wake_idx_q,
  input  logic [RD_PORTS*IDX_W-1:0]    rd_idx,
  output logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [IDX_W:0]               occupancy_q,
  output logic                         full_q
);

  localparam int OCC_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_TAIL    = 2'd1,
    ST_CHAINED = 2'd2,
    ST_EVICT   = 2'd3
  } entry_st_e;

  logic [ADDR_W-1:0]      addr_q     [ENTRIES];
  entry_st_e              st_q       [ENTRIES];
  logic [IDX_W-1:0]       pred_idx_q [ENTRIES];
  logic [ENTRIES-1:0]     pred_vld_q;

  logic                   req_valid_s1;
  logic [ADDR_W-1:0]      req_addr_s1;
  logic                   pipe_valid_sx3;
  logic [ADDR_W-1:BLK_OFF] pipe_line_sx3;
  logic [IDX_W-1:0]       pipe_idx_sx3;

  logic [ENTRIES-1:0]     wake_clr_vec;
  logic                   wake_any;
  logic [IDX_W-1:0]       wake_idx;
  logic [OCC_W-1:0]       occ_next;

  // Only the line portion of the pipeline address takes part in the compare.
  logic unused_pipe_offset;
  assign unused_pipe_offset = ^pipe_addr_sx2[BLK_OFF-1:0];

  // Advance the RXREQ and pipeline compare requests into their compare stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_s1   <= 1'b0;
      req_addr_s1    <= '0;
      pipe_valid_sx3 <= 1'b0;
      pipe_line_sx3  <= '0;
      pipe_idx_sx3   <= '0;
    end else begin
      req_valid_s1   <= req_valid_s0;
      req_addr_s1    <= req_addr_s0;
      pipe_valid_sx3 <= pipe_valid_sx2;
      pipe_line_sx3  <= pipe_addr_sx2[ADDR_W-1:BLK_OFF];
      pipe_idx_sx3   <= pipe_idx_sx2;
    end
  end

  // RXREQ compare: hit the TAIL of the same line unless it is leaving this cycle; highest index wins.
  always_comb begin
    req_hazard_s1     = 1'b0;
    req_hazard_idx_s1 = '0;
    req_hazard_vec_s1 = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (req_valid_s1 && st_q[e] == ST_TAIL &&
          addr_q[e][ADDR_W-1:BLK_OFF] == req_addr_s1[ADDR_W-1:BLK_OFF] &&
          !(retire_valid_sx1 && retire_idx_sx1 == IDX_W'(e)) &&
          !(evict_valid_sx7 && evict_idx_sx7 == IDX_W'(e))) begin
        req_hazard_s1     = 1'b1;
        req_hazard_idx_s1 = IDX_W'(e);
        req_hazard_vec_s1 = '0;
        req_hazard_vec_s1[e] = 1'b1;
      end
    end
  end

  // Pipeline compare: hit a pending eviction of the same line that is not retiring; highest index wins.
  always_comb begin
    pipe_hazard_sx3     = 1'b0;
    pipe_hazard_vec_sx3 = '0;
    pipe_sleep_vec_sx3  = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (pipe_valid_sx3 && st_q[e] == ST_EVICT &&
          addr_q[e][ADDR_W-1:BLK_OFF] == pipe_line_sx3 &&
          !(retire_valid_sx1 && retire_idx_sx1 == IDX_W'(e))) begin
        pipe_hazard_sx3     = 1'b1;
        pipe_hazard_vec_sx3 = '0;
        pipe_hazard_vec_sx3[e] = 1'b1;
      end
    end
    if (pipe_hazard_sx3) begin
      pipe_sleep_vec_sx3[pipe_idx_sx3] = 1'b1;
    end
  end

  // Find the successor chained behind the retiring entry.
  always_comb begin
    wake_clr_vec = '0;
    wake_any     = 1'b0;
    wake_idx     = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (retire_valid_sx1 && pred_vld_q[e] && pred_idx_q[e] == retire_idx_sx1) begin
        wake_clr_vec[e] = 1'b1;
        wake_any        = 1'b1;
        wake_idx        = IDX_W'(e);
      end
    end
  end

  // Per-entry state update with retire > evict > alloc > chain priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < ENTRIES; e++) begin
        addr_q[e]     <= '0;
        st_q[e]       <= ST_FREE;
        pred_idx_q[e] <= '0;
      end
      pred_vld_q <= '0;
    end else begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (wake_clr_vec[e]) begin
          pred_vld_q[e] <= 1'b0;
        end
        if (retire_valid_sx1 && retire_idx_sx1 == IDX_W'(e)) begin
          st_q[e]       <= ST_FREE;
          pred_vld_q[e] <= 1'b0;
        end else if (evict_valid_sx7 && evict_idx_sx7 == IDX_W'(e)) begin
          st_q[e]   <= ST_EVICT;
          addr_q[e] <= evict_addr_sx7;
        end else if (alloc_en_s1 && alloc_idx_s1 == IDX_W'(e)) begin
          st_q[e]   <= ST_TAIL;
          addr_q[e] <= req_addr_s1;
          if (req_hazard_s1) begin
            pred_idx_q[e] <= req_hazard_idx_s1;
            pred_vld_q[e] <= 1'b1;
          end
        end else if (alloc_en_s1 && req_hazard_s1 && req_hazard_idx_s1 == IDX_W'(e)) begin
          st_q[e] <= ST_CHAINED;
        end
      end
    end
  end

  // Next occupancy: alloc and retire in the same cycle cancel out.
  always_comb begin
    occ_next = occupancy_q;
    if (alloc_en_s1 && !retire_valid_sx1) begin
      occ_next = occupancy_q + OCC_W'(1);
    end else if (retire_valid_sx1 && !alloc_en_s1) begin
      occ_next = occupancy_q - OCC_W'(1);
    end
  end

  // Registered occupancy, full flag and single-cycle wake-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy_q  <= '0;
      full_q       <= 1'b0;
      wake_valid_q <= 1'b0;
      wake_idx_q   <= '0;
    end else begin
      occupancy_q  <= occ_next;
      full_q       <= (occ_next == OCC_W'(ENTRIES));
      wake_valid_q <= wake_any;
      if (wake_any) begin
        wake_idx_q <= wake_idx;
      end
    end
  end

  // Address read ports see the stored state, without bypass of this cycle's writes.
  always_comb begin
    rd_addr = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_addr[p*ADDR_W +: ADDR_W] = addr_q[rd_idx[p*IDX_W +: IDX_W]];
    end
  end

`ifndef SYNTHESIS
  a_alloc_free: assert property (@(posedge clk) disable iff (rst)
    alloc_en_s1 |-> st_q[alloc_idx_s1] == ST_FREE);
  a_retire_busy: assert property (@(posedge clk) disable iff (rst)
    retire_valid_sx1 |-> st_q[retire_idx_sx1] != ST_FREE);
  a_evict_busy: assert property (@(posedge clk) disable iff (rst)
    evict_valid_sx7 |-> st_q[evict_idx_sx7] != ST_FREE);
  a_alloc_retire: assert property (@(posedge clk) disable iff (rst)
    (alloc_en_s1 && retire_valid_sx1) |-> alloc_idx_s1 != retire_idx_sx1);
  a_alloc_evict: assert property (@(posedge clk) disable iff (rst)
    (alloc_en_s1 && evict_valid_sx7) |-> alloc_idx_s1 != evict_idx_sx7);
`endif

endmodule

// File: tb/tb_hnf_mshr_addr_cam.sv
// Bench for hnf_mshr_addr_cam: directed scenarios followed by randomized
// traffic, all checked against a line/chain level reference model.
module tb_hnf_mshr_addr_cam;

  localparam int ENTRIES  = 16;
  localparam int IDX_W    = 4;
  localparam int ADDR_W   = 48;
  localparam int BLK_OFF  = 6;
  localparam int RD_PORTS = 3;

  logic                       clk;
  logic                       rst;
  logic                       req_valid_s0;
  logic [ADDR_W-1:0]          req_addr_s0;
  logic                       alloc_en_s1;
  logic [IDX_W-1:0]           alloc_idx_s1;
  logic                       req_hazard_s1;
  logic [IDX_W-1:0]           req_hazard_idx_s1;
  logic [ENTRIES-1:0]         req_hazard_vec_s1;
  logic                       evict_valid_sx7;
  logic [IDX_W-1:0]           evict_idx_sx7;
  logic [ADDR_W-1:0]          evict_addr_sx7;
  logic                       pipe_valid_sx2;
  logic [ADDR_W-1:0]          pipe_addr_sx2;
  logic [IDX_W-1:0]           pipe_idx_sx2;
  logic                       pipe_hazard_sx3;
  logic [ENTRIES-1:0]         pipe_hazard_vec_sx3;
  logic [ENTRIES-1:0]         pipe_sleep_vec_sx3;
  logic                       retire_valid_sx1;
  logic [IDX_W-1:0]           retire_idx_sx1;
  logic                       wake_valid_q;
  logic [IDX_W-1:0]           wake_idx_q;
  logic [RD_PORTS*IDX_W-1:0]  rd_idx;
  logic [RD_PORTS*ADDR_W-1:0] rd_addr;
  logic [IDX_W:0]             occupancy_q;
  logic                       full_q;

  hnf_mshr_addr_cam #(
    .ENTRIES(ENTRIES), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .BLK_OFF(BLK_OFF), .RD_PORTS(RD_PORTS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_s0(req_valid_s0), .req_addr_s0(req_addr_s0),
    .alloc_en_s1(alloc_en_s1), .alloc_idx_s1(alloc_idx_s1),
    .req_hazard_s1(req_hazard_s1), .req_hazard_idx_s1(req_hazard_idx_s1),
    .req_hazard_vec_s1(req_hazard_vec_s1),
    .evict_valid_sx7(evict_valid_sx7), .evict_idx_sx7(evict_idx_sx7),
    .evict_addr_sx7(evict_addr_sx7),
    .pipe_valid_sx2(pipe_valid_sx2), .pipe_addr_sx2(pipe_addr_sx2), .pipe_idx_sx2(pipe_idx_sx2),
    .pipe_hazard_sx3(pipe_hazard_sx3), .pipe_hazard_vec_sx3(pipe_hazard_vec_sx3),
    .pipe_sleep_vec_sx3(pipe_sleep_vec_sx3),
    .retire_valid_sx1(retire_valid_sx1), .retire_idx_sx1(retire_idx_sx1),
    .wake_valid_q(wake_valid_q), .wake_idx_q(wake_idx_q),
    .rd_idx(rd_idx), .rd_addr(rd_addr),
    .occupancy_q(occupancy_q), .full_q(full_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: an entry is in use, possibly evicting, possibly the
  // youngest of its line's chain, and may wait behind a predecessor (-1: none).
  logic [ADDR_W-1:0] m_addr  [ENTRIES];
  bit                m_used  [ENTRIES];
  bit                m_evict [ENTRIES];
  bit                m_tail  [ENTRIES];
  int                m_pred  [ENTRIES];
  bit                m_req_v1;
  logic [ADDR_W-1:0] m_req_a1;
  bit                m_pipe_v3;
  logic [ADDR_W-1:0] m_pipe_a3;
  int                m_pipe_i3;
  bit                m_wake_v;
  int                m_wake_i;

  bit exp_req_hit;
  int exp_req_idx;
  bit exp_pipe_hit;
  int exp_pipe_idx;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic bit same_line(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return (a >> BLK_OFF) == (b >> BLK_OFF);
  endfunction

  function automatic logic [ADDR_W-1:0] fill_addr(input int i);
    return 48'h4000_0000 + 48'(i) * 48'd64 + 48'd5;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return {16'($urandom), 32'($urandom)};
    return 48'h2000_0000 + 48'($urandom_range(0, 3)) * 48'd64 + 48'($urandom_range(0, 63));
  endfunction

  function automatic int model_occ();
    int n = 0;
    for (int e = 0; e < ENTRIES; e++) if (m_used[e]) n++;
    return n;
  endfunction

  task automatic resetModel();
    for (int e = 0; e < ENTRIES; e++) begin
      m_addr[e] = '0; m_used[e] = 0; m_evict[e] = 0; m_tail[e] = 0; m_pred[e] = -1;
    end
    m_req_v1 = 0; m_req_a1 = '0; m_pipe_v3 = 0; m_pipe_a3 = '0; m_pipe_i3 = 0;
    m_wake_v = 0; m_wake_i = 0;
  endtask

  task automatic clearInputs();
    req_valid_s0 = 0; req_addr_s0 = '0; alloc_en_s1 = 0; alloc_idx_s1 = '0;
    evict_valid_sx7 = 0; evict_idx_sx7 = '0; evict_addr_sx7 = '0;
    pipe_valid_sx2 = 0; pipe_addr_sx2 = '0; pipe_idx_sx2 = '0;
    retire_valid_sx1 = 0; retire_idx_sx1 = '0; rd_idx = '0;
  endtask

  task automatic computeExpected();
    exp_req_hit = 0; exp_req_idx = 0; exp_pipe_hit = 0; exp_pipe_idx = 0;
    for (int e = 0; e < ENTRIES; e++) begin
      bit leaving = retire_valid_sx1 && int'(retire_idx_sx1) == e;
      bit evicting = evict_valid_sx7 && int'(evict_idx_sx7) == e;
      if (m_req_v1 && m_used[e] && !m_evict[e] && m_tail[e] && same_line(m_addr[e], m_req_a1)
          && !leaving && !evicting) begin
        exp_req_hit = 1; exp_req_idx = e;
      end
      if (m_pipe_v3 && m_used[e] && m_evict[e] && same_line(m_addr[e], m_pipe_a3) && !leaving) begin
        exp_pipe_hit = 1; exp_pipe_idx = e;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("req_hazard", 64'(req_hazard_s1), 64'(exp_req_hit));
    if (exp_req_hit) checkOutput("req_hazard_idx", 64'(req_hazard_idx_s1), 64'(exp_req_idx));
    checkOutput("req_hazard_vec", 64'(req_hazard_vec_s1), exp_req_hit ? (64'd1 << exp_req_idx) : 64'd0);
    checkOutput("pipe_hazard", 64'(pipe_hazard_sx3), 64'(exp_pipe_hit));
    checkOutput("pipe_hazard_vec", 64'(pipe_hazard_vec_sx3), exp_pipe_hit ? (64'd1 << exp_pipe_idx) : 64'd0);
    checkOutput("pipe_sleep_vec", 64'(pipe_sleep_vec_sx3), exp_pipe_hit ? (64'd1 << m_pipe_i3) : 64'd0);
    checkOutput("wake_valid", 64'(wake_valid_q), 64'(m_wake_v));
    if (m_wake_v) checkOutput("wake_idx", 64'(wake_idx_q), 64'(m_wake_i));
    checkOutput("occupancy", 64'(occupancy_q), 64'(model_occ()));
    checkOutput("full", 64'(full_q), 64'(model_occ() == ENTRIES));
    for (int p = 0; p < RD_PORTS; p++) begin
      checkOutput("rd_addr", 64'(rd_addr[p*ADDR_W +: ADDR_W]), 64'(m_addr[rd_idx[p*IDX_W +: IDX_W]]));
    end
  endtask

  task automatic updateModel();
    int r, v, a, s;
    if (rst) begin
      resetModel();
      return;
    end
    r = retire_valid_sx1 ? int'(retire_idx_sx1) : -1;
    v = evict_valid_sx7 ? int'(evict_idx_sx7) : -1;
    a = alloc_en_s1 ? int'(alloc_idx_s1) : -1;
    s = -1;
    if (r >= 0) for (int e = 0; e < ENTRIES; e++) if (m_pred[e] == r) s = e;
    m_wake_v = (s >= 0);
    if (s >= 0) begin
      m_wake_i = s;
      m_pred[s] = -1;
    end
    if (r >= 0) begin
      m_used[r] = 0; m_evict[r] = 0; m_tail[r] = 0; m_pred[r] = -1;
    end
    if (v >= 0) begin
      m_evict[v] = 1; m_addr[v] = evict_addr_sx7;
    end
    if (a >= 0) begin
      m_used[a] = 1; m_evict[a] = 0; m_tail[a] = 1; m_addr[a] = m_req_a1;
      m_pred[a] = exp_req_hit ? exp_req_idx : -1;
      if (exp_req_hit) m_tail[exp_req_idx] = 0;
    end
    m_req_v1 = req_valid_s0; m_req_a1 = req_addr_s0;
    m_pipe_v3 = pipe_valid_sx2; m_pipe_a3 = pipe_addr_sx2; m_pipe_i3 = int'(pipe_idx_sx2);
  endtask

  // Inputs are driven at the falling edge; check, advance the model, wait for the next falling edge.
  task automatic runCycle();
    #1;
    computeExpected();
    if (!rst) compareAll();
    updateModel();
    @(negedge clk);
  endtask

  task automatic applyStimulus();
    int busy[$];
    int free[$];
    int r = -1;
    clearInputs();
    for (int e = 0; e < ENTRIES; e++) if (m_used[e]) busy.push_back(e); else free.push_back(e);
    req_valid_s0 = ($urandom_range(0, 9) < 6);
    req_addr_s0 = rand_addr();
    if (busy.size() > 0 && $urandom_range(0, 99) < 35) begin
      r = busy[$urandom_range(0, busy.size() - 1)];
      retire_valid_sx1 = 1; retire_idx_sx1 = IDX_W'(r);
    end
    if (busy.size() > 0 && $urandom_range(0, 99) < 20) begin
      int v = busy[$urandom_range(0, busy.size() - 1)];
      if (v != r) begin
        evict_valid_sx7 = 1; evict_idx_sx7 = IDX_W'(v); evict_addr_sx7 = rand_addr();
      end
    end
    if (m_req_v1 && free.size() > 0 && $urandom_range(0, 9) < 7) begin
      alloc_en_s1 = 1; alloc_idx_s1 = IDX_W'(free[$urandom_range(0, free.size() - 1)]);
    end
    pipe_valid_sx2 = ($urandom_range(0, 9) < 6);
    pipe_addr_sx2 = rand_addr();
    pipe_idx_sx2 = IDX_W'($urandom_range(0, ENTRIES - 1));
    rd_idx = RD_PORTS*IDX_W'($urandom);
  endtask

  initial begin
    int free_q[$];
    clearInputs();
    resetModel();
    rst = 1;
    @(negedge clk);
    runCycle();
    rst = 0;
    // Reset state.
    #1;
    checkOutput("rst_occupancy", 64'(occupancy_q), 64'd0);
    checkOutput("rst_wake", 64'(wake_valid_q), 64'd0);
    checkOutput("rst_hazard", 64'(req_hazard_s1 | pipe_hazard_sx3), 64'd0);
    runCycle();

    // Chain entry 5 behind entry 2 on the same line.
    req_valid_s0 = 1; req_addr_s0 = 48'h1000_0040;
    runCycle();
    alloc_en_s1 = 1; alloc_idx_s1 = 4'd2; req_addr_s0 = 48'h1000_0078;
    runCycle();
    clearInputs(); alloc_en_s1 = 1; alloc_idx_s1 = 4'd5;
    #1;
    checkOutput("tp_hazard", 64'(req_hazard_s1), 64'd1);
    checkOutput("tp_hazard_idx", 64'(req_hazard_idx_s1), 64'd2);
    checkOutput("tp_hazard_vec", 64'(req_hazard_vec_s1), 64'h0004);
    runCycle();
    clearInputs(); retire_valid_sx1 = 1; retire_idx_sx1 = 4'd2;
    #1;
    checkOutput("tp_occ_before", 64'(occupancy_q), 64'd2);
    runCycle();
    clearInputs();
    #1;
    checkOutput("tp_wake_valid", 64'(wake_valid_q), 64'd1);
    checkOutput("tp_wake_idx", 64'(wake_idx_q), 64'd5);
    checkOutput("tp_occ_after", 64'(occupancy_q), 64'd1);
    runCycle();
    #1;
    checkOutput("tp_wake_once", 64'(wake_valid_q), 64'd0);

    // Eviction hazard on entry 3, then masked by its own retire.
    req_valid_s0 = 1; req_addr_s0 = 48'h3000_0000;
    runCycle();
    clearInputs(); alloc_en_s1 = 1; alloc_idx_s1 = 4'd3;
    runCycle();
    clearInputs(); evict_valid_sx7 = 1; evict_idx_sx7 = 4'd3; evict_addr_sx7 = 48'h2000_0000;
    pipe_valid_sx2 = 1; pipe_addr_sx2 = 48'h2000_0010; pipe_idx_sx2 = 4'd7;
    runCycle();
    clearInputs(); pipe_valid_sx2 = 1; pipe_addr_sx2 = 48'h2000_0010; pipe_idx_sx2 = 4'd7;
    #1;
    checkOutput("tp_pipe_hazard", 64'(pipe_hazard_sx3), 64'd1);
    checkOutput("tp_pipe_vec", 64'(pipe_hazard_vec_sx3), 64'h0008);
    checkOutput("tp_sleep_vec", 64'(pipe_sleep_vec_sx3), 64'h0080);
    runCycle();
    clearInputs(); retire_valid_sx1 = 1; retire_idx_sx1 = 4'd3;
    #1;
    checkOutput("tp_pipe_masked", 64'({pipe_hazard_sx3, pipe_hazard_vec_sx3, pipe_sleep_vec_sx3}), 64'd0);
    runCycle();

    // RXREQ hit masked by a same-cycle retire; alloc+retire keeps occupancy.
    clearInputs(); req_valid_s0 = 1; req_addr_s0 = 48'h5000_0100;
    runCycle();
    alloc_en_s1 = 1; alloc_idx_s1 = 4'd4;
    runCycle();
    clearInputs(); alloc_en_s1 = 1; alloc_idx_s1 = 4'd6; retire_valid_sx1 = 1; retire_idx_sx1 = 4'd4;
    #1;
    checkOutput("tp_retire_mask", 64'(req_hazard_s1), 64'd0);
    checkOutput("tp_occ_same_a", 64'(occupancy_q), 64'd2);
    runCycle();
    clearInputs();
    #1;
    checkOutput("tp_occ_same_b", 64'(occupancy_q), 64'd2);

    // Fill every remaining entry.
    for (int e = 0; e < ENTRIES; e++) if (!m_used[e]) free_q.push_back(e);
    for (int j = 0; j <= free_q.size(); j++) begin
      clearInputs();
      if (j < free_q.size()) begin
        req_valid_s0 = 1; req_addr_s0 = fill_addr(free_q[j]);
      end
      if (j > 0) begin
        alloc_en_s1 = 1; alloc_idx_s1 = IDX_W'(free_q[j-1]);
      end
      runCycle();
    end
    clearInputs();
    rd_idx = {4'd7, 4'd15, 4'd0};
    #1;
    checkOutput("tp_full", 64'(full_q), 64'd1);
    checkOutput("tp_occ_full", 64'(occupancy_q), 64'd16);
    checkOutput("tp_rd0", 64'(rd_addr[0 +: ADDR_W]), 64'(fill_addr(0)));
    checkOutput("tp_rd15", 64'(rd_addr[ADDR_W +: ADDR_W]), 64'(fill_addr(15)));
    checkOutput("tp_rd7", 64'(rd_addr[2*ADDR_W +: ADDR_W]), 64'(fill_addr(7)));
    runCycle();

    // Reset mid-operation with a retire that must be ignored.
    rst = 1; retire_valid_sx1 = 1; retire_idx_sx1 = 4'd0;
    runCycle();
    rst = 0; clearInputs(); req_valid_s0 = 1; req_addr_s0 = fill_addr(0);
    #1;
    checkOutput("tp_rst_occ", 64'(occupancy_q), 64'd0);
    checkOutput("tp_rst_full", 64'(full_q), 64'd0);
    runCycle();
    clearInputs();
    #1;
    checkOutput("tp_rst_nohaz", 64'(req_hazard_s1), 64'd0);
    runCycle();

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      rst = (i == 1500 || i == 1501);
      runCycle();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
